// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Shares one AXI read channel (AR/R) between the instruction cache
// (requester 0) and the data cache (requester 1). One burst is outstanding
// at a time; the grant is held from the AR handshake until the R beat that
// carries rlast. Ties between the two requesters are broken round-robin.
//
// Handshake rule used on every channel here: a transfer happens on a
// rising clk edge where valid and ready are both high. Valid does not wait
// for ready. Ready may depend combinationally on valid.
//
// The write channels do not pass through this block.

module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    // requester 0 (instruction cache)
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [ID_WIDTH-1:0]   s0_rid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,

    // requester 1 (data cache)
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [ID_WIDTH-1:0]   s1_rid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,

    // shared bus read channel
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    // status
    output logic                  busy,
    output logic                  grant,
    output logic                  protocol_err,
    // debug view of the arbiter state (0 idle, 1 addr, 2 data)
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic [7:0] exp_len;

    // AR fields of whichever requester currently holds the grant
    logic [ID_WIDTH-1:0]   sel_arid;
    logic [ADDR_WIDTH-1:0] sel_araddr;
    logic [7:0]            sel_arlen;
    logic [2:0]            sel_arsize;
    logic [1:0]            sel_arburst;
    logic                  sel_arvalid;
    logic                  sel_rready;

    logic in_addr;
    logic in_data;
    logic route0;
    logic route1;
    logic ar_hs;
    logic r_beat;

    // Select the granted requester's request and R-ready
    always_comb begin
        sel_arid    = s0_arid;
        sel_araddr  = s0_araddr;
        sel_arlen   = s0_arlen;
        sel_arsize  = s0_arsize;
        sel_arburst = s0_arburst;
        sel_arvalid = s0_arvalid;
        sel_rready  = s0_rready;
        if (grant) begin
            sel_arid    = s1_arid;
            sel_araddr  = s1_araddr;
            sel_arlen   = s1_arlen;
            sel_arsize  = s1_arsize;
            sel_arburst = s1_arburst;
            sel_arvalid = s1_arvalid;
            sel_rready  = s1_rready;
        end
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    // Bus AR side: only valid while we are presenting an address
    assign m_axi_arid    = sel_arid;
    assign m_axi_araddr  = sel_araddr;
    assign m_axi_arlen   = sel_arlen;
    assign m_axi_arsize  = sel_arsize;
    assign m_axi_arburst = sel_arburst;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = in_addr & sel_arvalid;

    // The bus arready is passed straight through to the granted requester
    assign s0_arready = in_addr & ~grant & m_axi_arready;
    assign s1_arready = in_addr &  grant & m_axi_arready;

    // R beats are consumed only in DATA; outside it rready stays low so a
    // stray beat is never swallowed
    assign m_axi_rready = in_data & sel_rready;

    assign route0 = in_data & ~grant;
    assign route1 = in_data &  grant;

    // R routing to requester 0; zero when not the data owner
    always_comb begin
        s0_rid    = '0;
        s0_rdata  = '0;
        s0_rresp  = 2'd0;
        s0_rlast  = 1'b0;
        s0_rvalid = 1'b0;
        if (route0) begin
            s0_rid    = m_axi_rid;
            s0_rdata  = m_axi_rdata;
            s0_rresp  = m_axi_rresp;
            s0_rlast  = m_axi_rlast;
            s0_rvalid = m_axi_rvalid;
        end
    end

    // R routing to requester 1; zero when not the data owner
    always_comb begin
        s1_rid    = '0;
        s1_rdata  = '0;
        s1_rresp  = 2'd0;
        s1_rlast  = 1'b0;
        s1_rvalid = 1'b0;
        if (route1) begin
            s1_rid    = m_axi_rid;
            s1_rdata  = m_axi_rdata;
            s1_rresp  = m_axi_rresp;
            s1_rlast  = m_axi_rlast;
            s1_rvalid = m_axi_rvalid;
        end
    end

    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_beat = in_data & m_axi_rvalid & sel_rready;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Arbitration FSM, burst beat tracking and sticky protocol error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            beat_cnt     <= 8'd0;
            exp_len      <= 8'd0;
            protocol_err <= 1'b0;
        end else begin
            // An R beat offered while no burst is in its data phase is illegal
            if (m_axi_rvalid && !in_data) begin
                protocol_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (s0_arvalid || s1_arvalid) begin
                        // Contention goes to whoever did not win last time
                        if (s0_arvalid && s1_arvalid) begin
                            grant <= ~last_grant;
                        end else begin
                            grant <= s1_arvalid;
                        end
                        state <= ADDR;
                    end
                end

                ADDR: begin
                    if (!sel_arvalid) begin
                        // Requester withdrew; round-robin history untouched
                        state <= IDLE;
                    end else if (ar_hs) begin
                        exp_len  <= sel_arlen;
                        beat_cnt <= 8'd0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (r_beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (m_axi_rlast) begin
                            // rlast always ends the burst, even if early or late
                            if (beat_cnt != exp_len) begin
                                protocol_err <= 1'b1;
                            end
                            last_grant <= grant;
                            state      <= IDLE;
                        end else if (beat_cnt == exp_len) begin
                            // Final beat without rlast: flag it, keep waiting
                            protocol_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Testbench for axi_rd_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against an
// ownership-level model of the shared read channel.

module tb_axi_rd_arbiter;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [IDW-1:0] s_arid[2];
  logic [AW-1:0]  s_araddr[2];
  logic [7:0]     s_arlen[2];
  logic [2:0]     s_arsize[2];
  logic [1:0]     s_arburst[2];
  logic           s_arvalid[2];
  logic           s_arready[2];
  logic [IDW-1:0] s_rid[2];
  logic [DW-1:0]  s_rdata[2];
  logic [1:0]     s_rresp[2];
  logic           s_rlast[2];
  logic           s_rvalid[2];
  logic           s_rready[2];

  logic [IDW-1:0] m_axi_arid;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_arlock;
  logic [3:0]     m_axi_arcache;
  logic [2:0]     m_axi_arprot;
  logic           m_axi_arvalid;
  logic           m_axi_arready;
  logic [IDW-1:0] m_axi_rid;
  logic [DW-1:0]  m_axi_rdata;
  logic [1:0]     m_axi_rresp;
  logic           m_axi_rlast;
  logic           m_axi_rvalid;
  logic           m_axi_rready;
  logic           busy;
  logic           grant;
  logic           protocol_err;
  logic [1:0]     state_dbg;

  axi_rd_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .s0_arid(s_arid[0]), .s0_araddr(s_araddr[0]), .s0_arlen(s_arlen[0]),
    .s0_arsize(s_arsize[0]), .s0_arburst(s_arburst[0]), .s0_arvalid(s_arvalid[0]),
    .s0_arready(s_arready[0]), .s0_rid(s_rid[0]), .s0_rdata(s_rdata[0]),
    .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]), .s0_rvalid(s_rvalid[0]),
    .s0_rready(s_rready[0]),
    .s1_arid(s_arid[1]), .s1_araddr(s_araddr[1]), .s1_arlen(s_arlen[1]),
    .s1_arsize(s_arsize[1]), .s1_arburst(s_arburst[1]), .s1_arvalid(s_arvalid[1]),
    .s1_arready(s_arready[1]), .s1_rid(s_rid[1]), .s1_rdata(s_rdata[1]),
    .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]), .s1_rvalid(s_rvalid[1]),
    .s1_rready(s_rready[1]),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .grant(grant), .protocol_err(protocol_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q0[$];
  logic [DW-1:0] got_q1[$];
  int            got_last[2];
  logic [AW-1:0] ar_log[$];

  // ---------------- behavioural model ----------------
  // own: -1 = channel free, else the requester that owns it.
  // in_burst: the owner's address has been accepted and data is flowing.
  int own;
  bit in_burst;
  int beats_done;
  int burst_len;
  bit err_seen;
  int cur_owner;
  int prev_winner;
  bit hs[2];
  bit hold[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own         = -1;
    in_burst    = 1'b0;
    beats_done  = 0;
    burst_len   = 0;
    err_seen    = 1'b0;
    cur_owner   = 0;
    prev_winner = 1;
    hs[0]       = 1'b0;
    hs[1]       = 1'b0;
  endtask

  // Advance the model over one clock edge using the inputs held during it
  task automatic model_update();
    if (m_axi_rvalid && !(own >= 0 && in_burst)) err_seen = 1'b1;
    if (own < 0) begin
      if (s_arvalid[0] || s_arvalid[1]) begin
        if (s_arvalid[0] && s_arvalid[1]) own = 1 - prev_winner;
        else own = s_arvalid[1] ? 1 : 0;
        cur_owner = own;
        in_burst  = 1'b0;
      end
    end else if (!in_burst) begin
      if (!s_arvalid[own]) begin
        own = -1;
      end else if (m_axi_arready) begin
        burst_len  = int'(s_arlen[own]);
        beats_done = 0;
        in_burst   = 1'b1;
        hs[own]    = 1'b1;
      end
    end else if (m_axi_rvalid && s_rready[own]) begin
      if (m_axi_rlast) begin
        if (beats_done != burst_len) err_seen = 1'b1;
        prev_winner = own;
        own         = -1;
        in_burst    = 1'b0;
      end else begin
        if (beats_done == burst_len) err_seen = 1'b1;
        beats_done = (beats_done + 1) % 256;
      end
    end
  endtask

  // Compare every DUT output against what the model says it must be now
  task automatic check_outputs();
    bit ad;
    bit dd;
    int o;
    logic exp_arv;
    ad = (own >= 0) && !in_burst;
    dd = (own >= 0) && in_burst;
    o  = (own < 0) ? 0 : own;
    chk("busy", busy, (own >= 0));
    chk("grant", grant, cur_owner[0]);
    chk("protocol_err", protocol_err, err_seen);
    chk("ar_consts", {m_axi_arlock, m_axi_arcache, m_axi_arprot}, 0);
    exp_arv = ad ? s_arvalid[o] : 1'b0;
    chk("m_arvalid", m_axi_arvalid, exp_arv);
    if (exp_arv) begin
      chk("m_arid", m_axi_arid, s_arid[o]);
      chk("m_araddr", m_axi_araddr, s_araddr[o]);
      chk("m_arlen", m_axi_arlen, s_arlen[o]);
      chk("m_arsize", m_axi_arsize, s_arsize[o]);
      chk("m_arburst", m_axi_arburst, s_arburst[o]);
    end
    chk("m_rready", m_axi_rready, dd ? s_rready[o] : 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("s%0d_arready", i), s_arready[i], (ad && own == i) ? m_axi_arready : 1'b0);
      chk($sformatf("s%0d_rvalid", i), s_rvalid[i], (dd && own == i) ? m_axi_rvalid : 1'b0);
      if (dd && own == i) begin
        chk($sformatf("s%0d_rid", i), s_rid[i], m_axi_rid);
        chk($sformatf("s%0d_rdata", i), s_rdata[i], m_axi_rdata);
        chk($sformatf("s%0d_rresp", i), s_rresp[i], m_axi_rresp);
        chk($sformatf("s%0d_rlast", i), s_rlast[i], m_axi_rlast);
      end else if (dd) begin
        chk($sformatf("s%0d_r_zero", i), {s_rid[i], s_rresp[i], s_rlast[i]}, 0);
        chk($sformatf("s%0d_rdata_zero", i), s_rdata[i], 0);
      end
    end
  endtask

  // One cycle: check mid-cycle, advance model at posedge, return at negedge
  task automatic step();
    #1;
    check_outputs();
    if (s_rvalid[0] && s_rready[0]) begin
      got_q0.push_back(s_rdata[0]);
      if (s_rlast[0]) got_last[0]++;
    end
    if (s_rvalid[1] && s_rready[1]) begin
      got_q1.push_back(s_rdata[1]);
      if (s_rlast[1]) got_last[1]++;
    end
    if (m_axi_arvalid && m_axi_arready) ar_log.push_back(m_axi_araddr);
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin
        hs[i] = 1'b0;
        if (!hold[i]) s_arvalid[i] = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic request(input int i, input logic [AW-1:0] addr, input logic [7:0] len);
    s_arvalid[i] = 1'b1;
    s_araddr[i]  = addr;
    s_arlen[i]   = len;
    s_arid[i]    = IDW'(i + 5);
    s_arsize[i]  = 3'd3;
    s_arburst[i] = 2'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait (bounded) for an AR request, stall arready for 'delay' cycles, accept
  task automatic bus_ar(input int delay);
    int t;
    t = 0;
    while (!m_axi_arvalid && t < 20) begin
      step();
      t++;
    end
    if (t == 20) begin
      checks++;
      failures++;
      $display("FAIL ar_wait_timeout actual=no_arvalid expected=arvalid_within_20");
    end
    m_axi_arready = 1'b0;
    repeat (delay) step();
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
  endtask

  // Present n back-to-back beats; rlast on beat index last_at
  task automatic bus_beats(input int n, input int last_at, input logic [DW-1:0] base);
    for (int b = 0; b < n; b++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = base + DW'(b);
      m_axi_rid    = IDW'(b);
      m_axi_rresp  = 2'd0;
      m_axi_rlast  = (b == last_at);
      step();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      s_arvalid[i] = 1'b0;
      s_arid[i]    = '0;
      s_araddr[i]  = '0;
      s_arlen[i]   = '0;
      s_arsize[i]  = '0;
      s_arburst[i] = '0;
      s_rready[i]  = 1'b1;
      hold[i]      = 1'b0;
    end
    m_axi_arready = 1'b0;
    m_axi_rid     = '0;
    m_axi_rdata   = '0;
    m_axi_rresp   = '0;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    got_last[0] = 0;
    got_last[1] = 0;
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", protocol_err, 0);
    chk("rst_state", state_dbg, 0);

    // T1: single s0 burst, arlen=7, arready after 2 cycles, 8 beats
    request(0, 64'h1000, 8'd7);
    step();
    chk("t1_arvalid_cycle1", m_axi_arvalid, 1);
    chk("t1_araddr", m_axi_araddr, 64'h1000);
    bus_ar(2);
    bus_beats(8, 7, 64'd0);
    chk("t1_busy_after_rlast", busy, 0);
    chk("t1_err", protocol_err, 0);
    for (int b = 0; b < 8; b++) exp_q.push_back(DW'(b));
    chk("t1_beat_count", got_q0.size(), 8);
    while (exp_q.size() > 0 && got_q0.size() > 0)
      chk("t1_beat_data", got_q0.pop_front(), exp_q.pop_front());
    exp_q.delete();
    chk("t1_rlast_seen", got_last[0], 1);
    chk("t1_s1_nothing", got_q1.size(), 0);

    // T2: simultaneous pairs after reset -> s0, s1, s0, s1
    do_reset();
    ar_log.delete();
    for (int p = 0; p < 2; p++) begin
      request(0, 64'h1000, 8'd3);
      request(1, 64'h2000, 8'd3);
      bus_ar(0);
      bus_beats(4, 3, 64'h100);
      bus_ar(1);
      bus_beats(4, 3, 64'h200);
    end
    chk("t2_ar_count", ar_log.size(), 4);
    if (ar_log.size() == 4) begin
      chk("t2_grant0", ar_log[0], 64'h1000);
      chk("t2_grant1", ar_log[1], 64'h2000);
      chk("t2_grant2", ar_log[2], 64'h1000);
      chk("t2_grant3", ar_log[3], 64'h2000);
    end

    // T3: both keep requesting -> strict alternation
    ar_log.delete();
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    request(0, 64'h1000, 8'd1);
    request(1, 64'h2000, 8'd1);
    for (int k = 0; k < 4; k++) begin
      bus_ar($urandom_range(0, 2));
      bus_beats(2, 1, 64'h300);
    end
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    s_arvalid[0] = 1'b0;
    s_arvalid[1] = 1'b0;
    step();
    step();
    chk("t3_ar_count", ar_log.size(), 4);
    if (ar_log.size() == 4) begin
      chk("t3_grant0", ar_log[0], 64'h1000);
      chk("t3_grant1", ar_log[1], 64'h2000);
      chk("t3_grant2", ar_log[2], 64'h1000);
      chk("t3_grant3", ar_log[3], 64'h2000);
    end

    // T4: early rlast on beat 3 with arlen=7; error is sticky
    do_reset();
    request(0, 64'h3000, 8'd7);
    bus_ar(0);
    bus_beats(3, 2, 64'h40);
    chk("t4_busy", busy, 0);
    chk("t4_err", protocol_err, 1);
    request(1, 64'h4000, 8'd1);
    bus_ar(1);
    bus_beats(2, 1, 64'h50);
    chk("t4_err_sticky", protocol_err, 1);

    // T5: spurious rvalid in IDLE
    do_reset();
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = 64'hdead;
    #1;
    chk("t5_rready_idle", m_axi_rready, 0);
    step();
    m_axi_rvalid = 1'b0;
    chk("t5_err", protocol_err, 1);

    // T6: async reset in the middle of a burst, then s1 is served normally
    do_reset();
    got_q1.delete();
    ar_log.delete();
    request(0, 64'h5000, 8'd7);
    bus_ar(0);
    bus_beats(4, 99, 64'h60);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = 64'h64;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_busy_async", busy, 0);
    chk("t6_s0_rvalid_async", s_rvalid[0], 0);
    chk("t6_rready_async", m_axi_rready, 0);
    chk("t6_state_async", state_dbg, 0);
    step();
    reset = 1'b0;
    m_axi_rvalid = 1'b0;
    step();
    request(1, 64'h6000, 8'd1);
    bus_ar(0);
    bus_beats(2, 1, 64'h70);
    chk("t6_s1_ar", (ar_log.size() > 0) ? ar_log[$] : 64'h0, 64'h6000);
    chk("t6_s1_beats", got_q1.size(), 2);
    chk("t6_err", protocol_err, 0);

    // Random traffic, checked every cycle by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int i = 0; i < 2; i++) begin
        if (!s_arvalid[i]) begin
          if ($urandom_range(0, 99) < 30)
            request(i, {$urandom, $urandom}, 8'($urandom_range(0, 5)));
        end else if ($urandom_range(0, 99) < 3) begin
          s_arvalid[i] = 1'b0;
        end
        s_rready[i] = ($urandom_range(0, 99) < 75);
      end
      m_axi_arready = ($urandom_range(0, 99) < 50);
      m_axi_rdata   = {$urandom, $urandom};
      m_axi_rid     = IDW'($urandom);
      m_axi_rresp   = 2'($urandom);
      r = $urandom_range(0, 99);
      if (own >= 0 && in_burst) begin
        m_axi_rvalid = ($urandom_range(0, 99) < 60);
        m_axi_rlast  = (beats_done == burst_len) ? (r < 97) : (r < 2);
      end else begin
        m_axi_rvalid = ($urandom_range(0, 199) == 0);
        m_axi_rlast  = 1'b0;
      end
      step();
      if (c % 700 == 699) begin
        idle_inputs();
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
